// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// =============================================================================
// pipe_hazard_ctrl : branch/jump flush, load-use stall and multicycle multu sequencer
// Revision: 1.0
// =============================================================================
module pipe_hazard_ctrl #(
  parameter int unsigned MUL_CYCLES = 32,
  parameter logic [5:0]  FN_MULTU   = 6'd25,
  parameter logic [5:0]  FN_MFHI    = 6'd16,
  parameter logic [5:0]  FN_MFLO    = 6'd18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  i_id_opcode,
  input  logic [5:0]  i_id_funct,
  input  logic [4:0]  i_id_rs,
  input  logic [4:0]  i_id_rt,
  input  logic [4:0]  i_ex_rt,
  input  logic        i_ex_memread,
  input  logic        i_ex_branch_taken,
  input  logic        i_ex_jump,
  output logic        o_pc_write,
  output logic        o_ifid_write,
  output logic        o_ifid_flush,
  output logic        o_idex_bubble,
  output logic        o_mul_start,
  output logic        o_mul_busy,
  output logic        o_mul_done,
  output logic [15:0] o_stall_cycles
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [5:0] C_CNT_INIT = 6'(MUL_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [5:0]  r_cnt;
  logic        r_mul_start;
  logic [15:0] r_stall_cycles;

  logic w_flush;
  logic w_load_use;
  logic w_mul_op;
  logic w_mul_stall;
  logic w_start;

  always_comb begin
    w_flush     = i_ex_branch_taken | i_ex_jump;
    w_load_use  = i_ex_memread && (i_ex_rt != 5'd0) &&
                  ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));
    w_mul_op    = (i_id_opcode == 6'd0) &&
                  ((i_id_funct == FN_MULTU) || (i_id_funct == FN_MFHI) ||
                   (i_id_funct == FN_MFLO));
    w_mul_stall = (r_state != S_IDLE) && w_mul_op;
    // A multu only launches once it actually leaves ID this cycle
    w_start     = (r_state == S_IDLE) && (i_id_opcode == 6'd0) &&
                  (i_id_funct == FN_MULTU) && !w_flush && !w_load_use;
  end

  always_comb begin
    o_pc_write    = 1'b1;
    o_ifid_write  = 1'b1;
    o_ifid_flush  = 1'b0;
    o_idex_bubble = 1'b0;
    if (!rst) begin
      if (w_flush) begin
        o_ifid_flush  = 1'b1;
        o_idex_bubble = 1'b1;
      end else if (w_load_use || w_mul_stall) begin
        o_pc_write    = 1'b0;
        o_ifid_write  = 1'b0;
        o_idex_bubble = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_BUSY;
      S_BUSY:  if (r_cnt == 6'd0) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= 6'd0;
      r_mul_start    <= 1'b0;
      r_stall_cycles <= 16'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_mul_start <= w_start;
      if (w_start) begin
        r_cnt <= C_CNT_INIT;
      end else if ((r_state == S_BUSY) && (r_cnt != 6'd0)) begin
        r_cnt <= r_cnt - 6'd1;
      end
      if (!o_pc_write && (r_stall_cycles != 16'hFFFF)) begin
        r_stall_cycles <= r_stall_cycles + 16'd1;
      end
    end
  end

  assign o_mul_start    = r_mul_start;
  assign o_mul_busy     = (r_state != S_IDLE);
  assign o_mul_done     = (r_state == S_DONE);
  assign o_stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// =============================================================================
// tb_pipe_hazard_ctrl : directed + randomized checks against a cycle-count model
// Revision: 1.0
// =============================================================================
module tb_pipe_hazard_ctrl;

  localparam int MC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  id_opcode = '0;
  logic [5:0]  id_funct  = '0;
  logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
  logic        ex_memread = 1'b0, ex_branch_taken = 1'b0, ex_jump = 1'b0;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble;
  logic        mul_start, mul_busy, mul_done;
  logic [15:0] stall_cycles;

  int n_tests = 0;
  int n_fail  = 0;
  int m_left  = 0;   // cycles the multiplier still reports busy (BUSY + DONE)
  int m_stalls = 0;

  pipe_hazard_ctrl #(.MUL_CYCLES(MC)) dut (
    .clk(clk), .rst(rst),
    .i_id_opcode(id_opcode), .i_id_funct(id_funct),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_ex_rt(ex_rt),
    .i_ex_memread(ex_memread), .i_ex_branch_taken(ex_branch_taken), .i_ex_jump(ex_jump),
    .o_pc_write(pc_write), .o_ifid_write(ifid_write), .o_ifid_flush(ifid_flush),
    .o_idex_bubble(idex_bubble), .o_mul_start(mul_start), .o_mul_busy(mul_busy),
    .o_mul_done(mul_done), .o_stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [22:0] observed();
    return {pc_write, ifid_write, ifid_flush, idex_bubble,
            mul_start, mul_busy, mul_done, stall_cycles};
  endfunction

  function automatic logic model_stall();
    logic fl, lu, mo;
    fl = ex_branch_taken | ex_jump;
    lu = ex_memread && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
    mo = id_opcode == 0 && (id_funct == 6'd25 || id_funct == 6'd16 || id_funct == 6'd18);
    return !rst && !fl && (lu || (m_left > 0 && mo));
  endfunction

  function automatic logic [22:0] model_expect();
    logic fl, st;
    if (rst) return {4'b1100, 3'b000, 16'd0};
    fl = ex_branch_taken | ex_jump;
    st = model_stall();
    return {!st, !st, fl, fl | st, m_left == MC + 1, m_left > 0, m_left == 1,
            16'(m_stalls)};
  endfunction

  // Advance the model across one rising edge using the inputs present before it.
  task automatic model_tick();
    logic st, go;
    st = model_stall();
    go = !rst && m_left == 0 && id_opcode == 0 && id_funct == 6'd25 &&
         !(ex_branch_taken | ex_jump) &&
         !(ex_memread && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt));
    @(posedge clk);
    if (rst) begin
      m_left = 0; m_stalls = 0;
    end else begin
      if (st && m_stalls < 65535) m_stalls++;
      if (m_left > 0) m_left--;
      else if (go) m_left = MC + 1;
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ert,
                       input logic mr, input logic bt, input logic jp);
    @(negedge clk);
    id_opcode = op; id_funct = fn; id_rs = rs; id_rt = rt; ex_rt = ert;
    ex_memread = mr; ex_branch_taken = bt; ex_jump = jp;
    #1;
  endtask

  task automatic do_reset();
    drive(6'd8, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    model_tick();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [22:0] o, e;
    drive(6'd0, 6'd25, 5'd3, 5'd3, 5'd3, 1'b1, 1'b0, 1'b0);
    rst = 1'b1; #1;
    o = observed(); e = {4'b1100, 3'b000, 16'd0};
    n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL reset_defaults got %h expected %h", o, e); end
    model_tick();
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_load_use();
    logic [22:0] o, e;
    do_reset();
    drive(6'd35, 6'd0, 5'd8, 5'd1, 5'd8, 1'b1, 1'b0, 1'b0);
    o = observed(); e = model_expect(); n_tests++;
    if (o !== e || o[22] !== 1'b0 || o[19] !== 1'b1) begin
      n_fail++; $display("FAIL load_use_stall got %h expected %h", o, e);
    end
    model_tick();
    drive(6'd35, 6'd0, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    o = observed(); e = model_expect(); n_tests++;
    if (o !== e || stall_cycles !== 16'd1 || pc_write !== 1'b1) begin
      n_fail++; $display("FAIL load_use_r0 got %h expected %h (stall_cycles 1)", o, e);
    end
    model_tick();
    drive(6'd35, 6'd0, 5'd2, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0);
    o = observed(); e = model_expect(); n_tests++;
    if (o !== e || ifid_flush !== 1'b1 || pc_write !== 1'b1) begin
      n_fail++; $display("FAIL flush_over_load_use got %h expected %h", o, e);
    end
    model_tick();
  endtask

  task automatic test_multiply();
    logic [22:0] o, e;
    int stalled = 0;
    do_reset();
    drive(6'd0, 6'd25, 5'd4, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    o = observed(); e = model_expect(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL multu_issue got %h expected %h", o, e); end
    model_tick();
    for (int c = 1; c <= 6; c++) begin
      drive(6'd0, 6'd16, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      o = observed(); e = model_expect(); n_tests++;
      if (o !== e) begin
        n_fail++; $display("FAIL mul_seq T+%0d got %h expected %h", c, o, e);
      end
      if (pc_write === 1'b0) stalled++;
      model_tick();
    end
    drive(6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    n_tests++;
    if (stalled != 5 || stall_cycles !== 16'd5 || mul_busy !== 1'b0) begin
      n_fail++; $display("FAIL mfhi_stall_total got %0d/%0d busy %b expected 5/5 busy 0",
                         stalled, stall_cycles, mul_busy);
    end
  endtask

  task automatic test_squash();
    logic [22:0] o, e;
    do_reset();
    drive(6'd0, 6'd25, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1);
    o = observed(); e = model_expect(); n_tests++;
    if (o !== e || ifid_flush !== 1'b1) begin
      n_fail++; $display("FAIL squash_flush got %h expected %h", o, e);
    end
    model_tick();
    drive(6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    o = observed(); e = model_expect(); n_tests++;
    if (o !== e || mul_start !== 1'b0 || mul_busy !== 1'b0) begin
      n_fail++; $display("FAIL squash_no_start got %h expected %h", o, e);
    end
    model_tick();
  endtask

  task automatic test_reset_mid();
    logic [22:0] o, e;
    int busy_n = 0, start_n = 0, done_n = 0;
    do_reset();
    drive(6'd0, 6'd25, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    model_tick();
    for (int c = 1; c <= 2; c++) begin
      drive(6'd0, 6'd16, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      model_tick();
    end
    drive(6'd0, 6'd16, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1; #1;
    o = observed(); e = {4'b1100, 3'b000, 16'd0}; n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL reset_mid_mul got %h expected %h", o, e); end
    model_tick();
    @(negedge clk); rst = 1'b0;
    drive(6'd0, 6'd25, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    model_tick();
    for (int c = 1; c <= 6; c++) begin
      drive(6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      o = observed(); e = model_expect(); n_tests++;
      if (o !== e) begin
        n_fail++; $display("FAIL restart_seq T+%0d got %h expected %h", c, o, e);
      end
      busy_n += int'(mul_busy); start_n += int'(mul_start); done_n += int'(mul_done);
      model_tick();
    end
    n_tests++;
    if (busy_n != 5 || start_n != 1 || done_n != 1) begin
      n_fail++; $display("FAIL restart_counts busy %0d start %0d done %0d expected 5 1 1",
                         busy_n, start_n, done_n);
    end
  endtask

  task automatic test_random();
    logic [22:0] o, e;
    logic [5:0]  op, fn;
    int errs = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      case ($urandom_range(0, 4))
        0, 1:    fn = 6'd25;
        2:       fn = 6'd16;
        3:       fn = 6'd18;
        default: fn = 6'($urandom);
      endcase
      drive(op, fn, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), $urandom_range(0, 9) < 3,
            $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
      o = observed(); e = model_expect(); n_tests++;
      if (o !== e) begin
        n_fail++;
        if (errs < 10) $display("FAIL random cyc %0d got %h expected %h", c, o, e);
        errs++;
      end
      model_tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_multiply();
    test_squash();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
